instruction_fetch: RTL

Multi-cycle fetch sequencer that sits directly upstream of the immediate generator and decoder. On a request from the control matrix it reads one 32-bit word from instruction memory at the supplied PC, over a variable-latency ready handshake. It captures the word into the instruction register (IR), whose output feeds the immediate generator and decoder, and records the PC of that instruction. Memory that never answers is detected by a bounded-wait timeout.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_timeout_counter.sv | 29 ++
 rtl/instruction_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        FAULT
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Bounded-wait counter for the fetch WAIT state.
// terminal_o is high while the count sits one below TIMEOUT_CYCLES, so the
// enabled edge that would reach TIMEOUT_CYCLES is the one that faults.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Count enabled cycles; clear has priority over enable.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal_o = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle instruction fetch sequencer: reads one word over a ready
// handshake, captures it into the IR and records its PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned PC faults
// with code 10 instead of being silently word-aligned).
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR   = '0,
    parameter int unsigned            TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fetch_req_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  mem_rd_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic [DATA_WIDTH-1:0] pc_prev_o,
    output logic                  ir_valid_o,
    output logic                  busy_o,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] pc_latch_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] pc_prev_q;
    logic                  fault_q;
    logic [1:0]            fault_code_q;

    logic count_clear;
    logic count_en;
    logic count_tc;
    logic req_misaligned;
    logic accept;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign req_misaligned = |pc_i[1:0];
`else
    assign req_misaligned = 1'b0;
`endif

    assign accept = (state_q == IDLE) && fetch_req_i;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (count_clear),
        .enable_i  (count_en),
        .terminal_o(count_tc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timeout counter control; ready beats the terminal count.
    always_comb begin
        state_d     = state_q;
        count_clear = 1'b0;
        count_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req_i) begin
                    count_clear = 1'b1;
                    state_d     = req_misaligned ? FAULT : WAIT;
                end
            end
            WAIT: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end else begin
                    count_en = 1'b1;
                    if (count_tc) begin
                        state_d = FAULT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/PC latch, IR capture and sticky fault bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_addr_q   <= RESET_VECTOR;
            pc_latch_q   <= RESET_VECTOR;
            ir_q         <= DATA_WIDTH'(NOP_INSN);
            pc_prev_q    <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else if (accept) begin
            if (req_misaligned) begin
                fault_q      <= 1'b1;
                fault_code_q <= FAULT_MISALIGN;
            end else begin
                mem_addr_q   <= {pc_i[DATA_WIDTH-1:2], 2'b00};
                pc_latch_q   <= pc_i;
                fault_q      <= 1'b0;
                fault_code_q <= FAULT_NONE;
            end
        end else if (state_q == WAIT) begin
            if (mem_ready_i) begin
                ir_q      <= mem_data_i;
                pc_prev_q <= pc_latch_q;
            end else if (count_tc) begin
                fault_q      <= 1'b1;
                fault_code_q <= FAULT_TIMEOUT;
            end
        end
    end

    assign mem_rd_o     = (state_q == WAIT);
    assign mem_addr_o   = mem_addr_q;
    assign ir_o         = ir_q;
    assign pc_prev_o    = pc_prev_q;
    assign ir_valid_o   = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;

endmodule
